jmp_seq_ctrl: RTL and testbench

Run controller for the team's 4-bit jump counter. It holds a small runtime-programmable table of jump pairs (`from` → `to`) in place of fixed constants, and sequences the counter through a requested number of laps. It drives `done` when the sequence finishes. It sits between a host/config master and any logic that consumes the count value.

---
 rtl/jmp_seq_ctrl_if.sv | 41 ++++
 rtl/jmp_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_jmp_seq_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/jmp_seq_ctrl_if.sv
// Host/config and run-control bundle for jmp_seq_ctrl.
// The pause signal exists only when JMP_SEQ_PAUSE_EN is defined.
interface jmp_seq_ctrl_if #(
    parameter int WIDTH   = 4,
    parameter int NUM_JMP = 2,
    parameter int LAP_W   = 8
);
    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [$clog2(NUM_JMP)-1:0] cfg_idx;
    logic [WIDTH-1:0]           cfg_from;
    logic [WIDTH-1:0]           cfg_to;
    logic                       cfg_en;
    logic                       start;
    logic                       stop;
    logic [LAP_W-1:0]           laps;
    logic [WIDTH-1:0]           count;
    logic                       busy;
    logic                       wrap;
    logic                       done;
    logic [LAP_W-1:0]           laps_left;
`ifdef JMP_SEQ_PAUSE_EN
    logic                       pause;
`endif

    modport master (
        output cfg_valid, cfg_idx, cfg_from, cfg_to, cfg_en, start, stop, laps,
`ifdef JMP_SEQ_PAUSE_EN
        output pause,
`endif
        input  cfg_ready, count, busy, wrap, done, laps_left
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_from, cfg_to, cfg_en, start, stop, laps,
`ifdef JMP_SEQ_PAUSE_EN
        input  pause,
`endif
        output cfg_ready, count, busy, wrap, done, laps_left
    );
endinterface

// File: rtl/jmp_seq_ctrl.sv
// Run controller for the 4-bit jump counter with a programmable jump table.
// Optional pause input is enabled by defining JMP_SEQ_PAUSE_EN.
module jmp_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int NUM_JMP = 2,
    parameter int LAP_W   = 8
) (
    input  logic          clk,
    input  logic          resetN,
    jmp_seq_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]             state;
    logic [WIDTH-1:0]       count_q;
    logic [LAP_W-1:0]       laps_left_q;
    logic                   wrap_q;
    logic                   done_q;
    logic [NUM_JMP-1:0][WIDTH-1:0] tbl_from;
    logic [NUM_JMP-1:0][WIDTH-1:0] tbl_to;
    logic [NUM_JMP-1:0]     tbl_en;
    logic [NUM_JMP-1:0]     tbl_match;
    logic                   hit;
    logic [WIDTH-1:0]       hit_to;
    logic                   run_hold;
    logic                   cfg_wr;

`ifdef JMP_SEQ_PAUSE_EN
    assign run_hold = bus.pause;
`else
    assign run_hold = 1'b0;
`endif

    assign cfg_wr = bus.cfg_valid && (state == ST_IDLE);

    genvar g;
    generate
        for (g = 0; g < NUM_JMP; g++) begin : g_ent
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    tbl_from[g] <= '0;
                    tbl_to[g]   <= '0;
                    tbl_en[g]   <= 1'b0;
                end else if (cfg_wr && (int'(bus.cfg_idx) == g)) begin
                    tbl_from[g] <= bus.cfg_from;
                    tbl_to[g]   <= bus.cfg_to;
                    tbl_en[g]   <= bus.cfg_en;
                end
            end
            assign tbl_match[g] = tbl_en[g] && (tbl_from[g] == count_q);
        end
    endgenerate

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        hit    = 1'b0;
        hit_to = '0;
        for (int i = NUM_JMP - 1; i >= 0; i--) begin
            if (tbl_match[i]) begin
                hit    = 1'b1;
                hit_to = tbl_to[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            count_q     <= '0;
            laps_left_q <= '0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state       <= ST_RUN;
                        count_q     <= '0;
                        laps_left_q <= bus.laps;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state <= ST_IDLE;
                    end else if (run_hold) begin
                        wrap_q <= wrap_q;
                    end else if (hit) begin
                        count_q <= hit_to;
                    end else if (count_q == CNT_MAX) begin
                        count_q <= '0;
                        wrap_q  <= 1'b1;
                        if (laps_left_q != '0) begin
                            laps_left_q <= laps_left_q - LAP_W'(1);
                        end
                        if (laps_left_q == LAP_W'(1)) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        count_q <= count_q + WIDTH'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_ready = (state == ST_IDLE);
    assign bus.busy      = (state == ST_RUN);
    assign bus.count     = count_q;
    assign bus.laps_left = laps_left_q;
    assign bus.wrap      = wrap_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_jmp_seq_ctrl.sv
// Directed self-checking bench for jmp_seq_ctrl.
module tb_jmp_seq_ctrl;
    logic clk;
    logic resetN;
    int   n_chk;
    int   n_err;

    jmp_seq_ctrl_if #(.WIDTH(4), .NUM_JMP(2), .LAP_W(8)) bus ();

    jmp_seq_ctrl #(.WIDTH(4), .NUM_JMP(2), .LAP_W(8)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [0:0] idx, input logic [3:0] f, input logic [3:0] t, input logic en);
        bus.cfg_valid = 1'b1;
        bus.cfg_idx   = idx;
        bus.cfg_from  = f;
        bus.cfg_to    = t;
        bus.cfg_en    = en;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] l);
        bus.start = 1'b1;
        bus.laps  = l;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    initial begin
        logic [3:0] seq1 [14];
        seq1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10,
                 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
        n_chk = 0;
        n_err = 0;
        resetN        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_idx   = '0;
        bus.cfg_from  = '0;
        bus.cfg_to    = '0;
        bus.cfg_en    = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.laps      = '0;
`ifdef JMP_SEQ_PAUSE_EN
        bus.pause     = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_wrap", 32'(bus.wrap), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_laps_left", 32'(bus.laps_left), 0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
        resetN = 1'b1;
        step();

        // single lap with a 6->9 jump
        cfg_write(1'b0, 4'd6, 4'd9, 1'b1);
        do_start(8'd1);
        chk("t1_start_count", 32'(bus.count), 0);
        chk("t1_start_busy", 32'(bus.busy), 1);
        chk("t1_start_laps", 32'(bus.laps_left), 1);
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("t1_count%0d", i), 32'(bus.count), 32'(seq1[i]));
            if (i == 12) chk("t1_no_wrap_yet", 32'(bus.wrap), 0);
        end
        chk("t1_wrap", 32'(bus.wrap), 1);
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_laps_left", 32'(bus.laps_left), 0);
        chk("t1_busy_in_done", 32'(bus.busy), 0);
        step();
        chk("t1_idle_ready", 32'(bus.cfg_ready), 1);
        chk("t1_idle_done", 32'(bus.done), 0);

        // overlapping entries: entry0 must win
        cfg_write(1'b0, 4'd3, 4'd12, 1'b1);
        cfg_write(1'b1, 4'd3, 4'd5, 1'b1);
        do_start(8'd2);
        for (int lap = 0; lap < 2; lap++) begin
            for (int s = 0; s < 4; s++) step();
            chk($sformatf("t2_jump_lap%0d", lap), 32'(bus.count), 12);
            for (int s = 0; s < 4; s++) step();
            chk($sformatf("t2_wrap_lap%0d", lap), 32'(bus.wrap), 1);
            chk($sformatf("t2_laps_left%0d", lap), 32'(bus.laps_left), 32'(1 - lap));
            chk($sformatf("t2_done%0d", lap), 32'(bus.done), 32'(lap));
        end
        step();

        // stop at count 7 in an endless run
        cfg_write(1'b0, 4'd0, 4'd0, 1'b0);
        cfg_write(1'b1, 4'd0, 4'd0, 1'b0);
        do_start(8'd0);
        for (int s = 0; s < 7; s++) step();
        chk("t3_pre_stop", 32'(bus.count), 7);
        do_stop();
        chk("t3_stop_count", 32'(bus.count), 7);
        chk("t3_stop_busy", 32'(bus.busy), 0);
        chk("t3_stop_done", 32'(bus.done), 0);
        step();
        chk("t3_idle_hold", 32'(bus.count), 7);
        do_start(8'd0);
        chk("t3_restart", 32'(bus.count), 0);

        // write attempt while running is blocked
        bus.cfg_valid = 1'b1;
        bus.cfg_idx   = 1'b0;
        bus.cfg_from  = 4'd2;
        bus.cfg_to    = 4'd14;
        bus.cfg_en    = 1'b1;
        step();
        step();
        chk("t4_ready_low", 32'(bus.cfg_ready), 0);
        chk("t4_at2", 32'(bus.count), 2);
        step();
        chk("t4_no_jump", 32'(bus.count), 3);
        bus.cfg_valid = 1'b0;
        do_stop();
        // write coincident with start applies to the first step
        bus.cfg_valid = 1'b1;
        bus.cfg_idx   = 1'b1;
        bus.cfg_from  = 4'd0;
        bus.cfg_to    = 4'd5;
        bus.cfg_en    = 1'b1;
        do_start(8'd0);
        bus.cfg_valid = 1'b0;
        chk("t4_start_count", 32'(bus.count), 0);
        step();
        chk("t4_first_jump", 32'(bus.count), 5);
        for (int s = 0; s < 6; s++) step();
        chk("t4_at11", 32'(bus.count), 11);

        // async reset between edges
        #2 resetN = 1'b0;
        #1;
        chk("t5_rst_count", 32'(bus.count), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_ready", 32'(bus.cfg_ready), 1);
        @(negedge clk);
        resetN = 1'b1;
        do_start(8'd1);
        for (int s = 1; s < 16; s++) begin
            step();
            chk($sformatf("t5_count%0d", s), 32'(bus.count), 32'(s));
        end
        step();
        chk("t5_wrap", 32'(bus.wrap), 1);
        chk("t5_done", 32'(bus.done), 1);
        step();

`ifdef JMP_SEQ_PAUSE_EN
        do_start(8'd0);
        for (int s = 0; s < 4; s++) step();
        bus.pause = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("t6_hold%0d", s), 32'(bus.count), 4);
        end
        bus.pause = 1'b0;
        step();
        chk("t6_resume", 32'(bus.count), 5);
        do_stop();
        do_start(8'd0);
        for (int s = 0; s < 4; s++) step();
        bus.pause = 1'b1;
        step();
        do_stop();
        bus.pause = 1'b0;
        chk("t6_stop_busy", 32'(bus.busy), 0);
        chk("t6_stop_count", 32'(bus.count), 4);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
